rn_crossbar_nport: RTL
======================

Name: rn_crossbar_nport

Overview:
- Parametrised single-initiator to NUM_TGT-target request/response crossbar for the APB-style interconnect.
- Replaces the fixed 4-way, handshake-less router with valid/ready handshakes, one outstanding transaction locked to the selected target, and a registered response return path.
- Invalid target selects produce an error response.
- Sits between the requester-side request buffer and the per-target interconnect ports.

Parameters:
- REQ_FLIT_WIDTH, `REQ_FLIT_WIDTH: request flit width.
- RSP_FLIT_WIDTH, `RSP_FLIT_WIDTH: response flit width.
- NUM_TGT, 4: number of target ports, range 2..15.
- SEL_WIDTH, $clog2(NUM_TGT+1): select width. Encoding: 1..NUM_TGT selects a target; 0 and values above NUM_TGT are invalid.
- TIMEOUT_CYCLES, 256: response timeout, used only with the optional feature.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  initiator request valid.
- req_ready  out  1  initiator request ready.
- sel  in  SEL_WIDTH  target select, sampled with the request.
- req_flit  in  REQ_FLIT_WIDTH  request flit.
- tgt_req_valid  out  NUM_TGT  per-target request valid, one-hot or zero.
- tgt_req_ready  in  NUM_TGT  per-target request ready.
- tgt_req_flit  out  NUM_TGT*REQ_FLIT_WIDTH  per-target flits; slice i = bits [i*REQ_FLIT_WIDTH +: REQ_FLIT_WIDTH].
- tgt_rsp_valid  in  NUM_TGT  per-target response valid, single-cycle pulse.
- tgt_rsp_flit  in  NUM_TGT*RSP_FLIT_WIDTH  per-target response flits.
- rsp_valid  out  1  response to initiator valid.
- rsp_ready  in  1  initiator accepts response.
- rsp_flit  out  RSP_FLIT_WIDTH  response flit.
- rsp_err  out  1  error qualifier, valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; tgt_req_valid=0, all tgt_req_flit slices=0, rsp_valid=0, rsp_flit=0, rsp_err=0, busy=0, timer=0.
  - Applies on the next edge from any state; an in-flight transaction is dropped with no response.
- States: IDLE, REQ, WAIT_RSP, RSP, ERR.
- IDLE:
  - req_ready=1; req_ready is 0 in every other state.
  - On req_valid && req_ready: latch sel into tgt_idx and req_flit into the holding register.
  - Valid sel: go to REQ. Invalid sel: go to ERR.
- REQ:
  - tgt_req_valid[tgt_idx]=1; slice tgt_idx carries the latched flit. All other slices are 0 and all other valid bits are 0.
  - First tgt_req_valid occurs one cycle after acceptance.
  - Valid and flit are held stable until tgt_req_ready[tgt_idx]=1.
  - On that handshake edge: go to WAIT_RSP; tgt_req_valid drops and the slice clears to 0 on the same edge.
- WAIT_RSP:
  - Only tgt_rsp_valid[tgt_idx] is observed; pulses on any other target are ignored.
  - On a pulse: capture tgt_rsp_flit slice into rsp_flit, set rsp_err=0, go to RSP.
  - rsp_valid rises one cycle after the target pulse.
  - A response arriving in the same cycle as the request handshake, while still in REQ, is ignored. Targets must respond at least one cycle after accepting.
- RSP:
  - rsp_valid=1; rsp_flit and rsp_err are held stable until rsp_ready.
  - On handshake: clear rsp_valid, rsp_flit and rsp_err; go to IDLE.
  - No back-to-back acceptance: minimum cycle from one acceptance to the next is 4 cycles.
- ERR:
  - rsp_valid=1, rsp_err=1, rsp_flit=0; no target port is touched.
  - On rsp_ready: go to IDLE.
- Output ordering: at most one response per accepted request, always in order.

Optional Feature:
- Macro: RN_CROSSBAR_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit timer clears on entry to WAIT_RSP and increments each cycle spent in WAIT_RSP.
  - When the timer reaches TIMEOUT_CYCLES-1 with no response: go to ERR (rsp_err=1, rsp_flit=0).
  - If a response and expiry occur in the same cycle, the response wins.
  - Late responses from the abandoned target are ignored.
- Undefined: no timer logic; WAIT_RSP waits indefinitely.

Decomposition:
- Package rn_crossbar_pkg holds:
  - state enum xbar_state_e {IDLE, REQ, WAIT_RSP, RSP, ERR};
  - localparam functions for SEL_WIDTH and timer width;
  - the ERR_RSP_FLIT constant (all zeros).
- One sub-module, rn_xbar_timeout_ctr: clear, enable, expire; instantiated only under the macro.
- Demux and mux stay inline in the top module.

Test Plan:
- Routing: NUM_TGT=4, sel=3, req_flit=0xA5, target 3 ready immediately, responds 0x3C two cycles later, rsp_ready=1 → only tgt_req_valid[2] pulses (1 cycle after accept) with slice 0xA5; rsp_flit=0x3C, rsp_err=0; back in IDLE.
- Backpressure: sel=1, tgt_req_ready[0] low for 5 cycles → valid and flit held stable for 6 cycles; req_ready stays 0; a second req_valid is not accepted.
- Invalid select: sel=0, then sel=5 → no tgt_req_valid asserted; rsp_valid=1, rsp_err=1, rsp_flit=0 for each; rsp_ready held low 3 cycles keeps the response stable.
- Cross-talk: in WAIT_RSP for target 2, pulse tgt_rsp_valid[0] with 0xFF → ignored; the later target-2 pulse with 0x11 → rsp_flit=0x11.
- Reset mid-operation: rst asserted in WAIT_RSP → next edge all outputs 0, busy=0, req_ready=1; a subsequent target response produces no rsp_valid.
- Timeout (macro defined, TIMEOUT_CYCLES=8): target never responds → rsp_err=1 exactly 8 cycles after entering WAIT_RSP. Repeat with the response in the expiry cycle → normal response, rsp_err=0.

Source files
------------

// File: rtl/rn_crossbar_pkg.sv
// rn_crossbar_pkg: state encoding, width helpers and constants shared by the rn_crossbar_nport slice.
// Flit widths default through the REQ_FLIT_WIDTH / RSP_FLIT_WIDTH macros when the build does not set them.
`ifndef REQ_FLIT_WIDTH
`define REQ_FLIT_WIDTH 32
`endif
`ifndef RSP_FLIT_WIDTH
`define RSP_FLIT_WIDTH 32
`endif

package rn_crossbar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        RSP,
        ERR
    } xbar_state_e;

    // Wide enough for any flit width in use; consumers slice off what they need.
    localparam int MAX_FLIT_WIDTH = 1024;
    localparam logic [MAX_FLIT_WIDTH-1:0] ERR_RSP_FLIT = '0;

    function automatic int sel_width(input int num_tgt);
        return $clog2(num_tgt + 1);
    endfunction

    function automatic int idx_width(input int num_tgt);
        return (num_tgt > 1) ? $clog2(num_tgt) : 1;
    endfunction

    function automatic int timer_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/rn_xbar_timeout_ctr.sv
// rn_xbar_timeout_ctr: response timer for rn_crossbar_nport; only instantiated when
// RN_CROSSBAR_TIMEOUT_EN is defined. expire flags the last cycle the crossbar may wait.
module rn_xbar_timeout_ctr
    import rn_crossbar_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_WIDTH = timer_width(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] timer;

    assign expire = enable && (timer == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Holding at the limit keeps the count sane if the owner lingers after expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable && !expire) begin
            timer <= timer + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rn_crossbar_nport.sv
// rn_crossbar_nport: single-initiator to NUM_TGT-target request/response crossbar, one transaction in flight.
// Define RN_CROSSBAR_TIMEOUT_EN to turn a target that never answers into an error response.
`ifndef REQ_FLIT_WIDTH
`define REQ_FLIT_WIDTH 32
`endif
`ifndef RSP_FLIT_WIDTH
`define RSP_FLIT_WIDTH 32
`endif

module rn_crossbar_nport
    import rn_crossbar_pkg::*;
#(
    parameter int REQ_FLIT_WIDTH = `REQ_FLIT_WIDTH,
    parameter int RSP_FLIT_WIDTH = `RSP_FLIT_WIDTH,
    parameter int NUM_TGT        = 4,
    parameter int SEL_WIDTH      = sel_width(NUM_TGT),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [SEL_WIDTH-1:0]              sel,
    input  logic [REQ_FLIT_WIDTH-1:0]         req_flit,
    output logic [NUM_TGT-1:0]                tgt_req_valid,
    input  logic [NUM_TGT-1:0]                tgt_req_ready,
    output logic [NUM_TGT*REQ_FLIT_WIDTH-1:0] tgt_req_flit,
    input  logic [NUM_TGT-1:0]                tgt_rsp_valid,
    input  logic [NUM_TGT*RSP_FLIT_WIDTH-1:0] tgt_rsp_flit,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [RSP_FLIT_WIDTH-1:0]         rsp_flit,
    output logic                              rsp_err,
    output logic                              busy
);

    localparam int IDX_WIDTH = idx_width(NUM_TGT);

    xbar_state_e                       state;
    logic [IDX_WIDTH-1:0]              tgt_idx;
    logic [IDX_WIDTH-1:0]              sel_idx;
    logic                              sel_valid;
    logic [NUM_TGT-1:0]                demux_valid;
    logic [NUM_TGT*REQ_FLIT_WIDTH-1:0] demux_flit;
    logic                              cur_req_ready;
    logic                              cur_rsp_valid;
    logic [RSP_FLIT_WIDTH-1:0]         cur_rsp_flit;
    logic                              timeout_expire;

    // Select 1..NUM_TGT maps to port sel-1; zero and anything past the last port is an error.
    assign sel_valid = (sel != '0) && (sel <= SEL_WIDTH'(NUM_TGT));
    assign sel_idx   = IDX_WIDTH'(sel - SEL_WIDTH'(1));

    // Request demux: only the selected slice carries the flit, every other slice stays zero.
    always_comb begin
        demux_valid = '0;
        demux_flit  = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (sel_idx == IDX_WIDTH'(i)) begin
                demux_valid[i]                                    = 1'b1;
                demux_flit[i*REQ_FLIT_WIDTH +: REQ_FLIT_WIDTH]    = req_flit;
            end
        end
    end

    // Handshake/response mux: only the locked target is ever observed.
    always_comb begin
        cur_req_ready = 1'b0;
        cur_rsp_valid = 1'b0;
        cur_rsp_flit  = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (tgt_idx == IDX_WIDTH'(i)) begin
                cur_req_ready = tgt_req_ready[i];
                cur_rsp_valid = tgt_rsp_valid[i];
                cur_rsp_flit  = tgt_rsp_flit[i*RSP_FLIT_WIDTH +: RSP_FLIT_WIDTH];
            end
        end
    end

`ifdef RN_CROSSBAR_TIMEOUT_EN
    rn_xbar_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != WAIT_RSP),
        .enable (state == WAIT_RSP),
        .expire (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
    wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // tgt_req_flit doubles as the request holding register while the target is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tgt_idx       <= '0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            tgt_req_valid <= '0;
            tgt_req_flit  <= '0;
            rsp_valid     <= 1'b0;
            rsp_flit      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        tgt_idx   <= sel_idx;
                        if (sel_valid) begin
                            state         <= REQ;
                            tgt_req_valid <= demux_valid;
                            tgt_req_flit  <= demux_flit;
                        end else begin
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_flit  <= ERR_RSP_FLIT[RSP_FLIT_WIDTH-1:0];
                        end
                    end
                end
                REQ: begin
                    if (cur_req_ready) begin
                        state         <= WAIT_RSP;
                        tgt_req_valid <= '0;
                        tgt_req_flit  <= '0;
                    end
                end
                WAIT_RSP: begin
                    // A response in the expiry cycle still counts as a normal response.
                    if (cur_rsp_valid) begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_flit  <= cur_rsp_flit;
                        rsp_err   <= 1'b0;
                    end else if (timeout_expire) begin
                        state     <= ERR;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_flit  <= ERR_RSP_FLIT[RSP_FLIT_WIDTH-1:0];
                    end
                end
                RSP, ERR: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b0;
                        rsp_flit  <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req_ready     <= 1'b1;
                    busy          <= 1'b0;
                    tgt_req_valid <= '0;
                    tgt_req_flit  <= '0;
                    rsp_valid     <= 1'b0;
                    rsp_flit      <= '0;
                    rsp_err       <= 1'b0;
                end
            endcase
        end
    end

endmodule
